ex_operand_fwd_stage: RTL

EX-stage operand select and EX/MEM pipeline register for the RV32I five-stage core. It consumes the two 3-bit forward-select codes from the forwarding unit and picks each ALU operand from one of two places: the ID/EX register-file value, or one of five later-stage producer values. It then captures the ALU result, the forwarded store data and the control fields into the EX/MEM register, with stall and flush. The registered fields feed the MEM stage and are also returned to the forwarding path.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/fwd_operand_mux.sv | 31 +++
 rtl/ex_operand_fwd_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline constants: datapath width, forward-select codes and
// memtoreg encodings, plus small decode helpers for the forward codes.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FWD_NONE   = 3'b000;
  localparam logic [2:0] FWD_EX_ALU = 3'b001;
  localparam logic [2:0] FWD_EX_PC4 = 3'b010;
  localparam logic [2:0] FWD_WB_ALU = 3'b011;
  localparam logic [2:0] FWD_WB_MEM = 3'b100;
  localparam logic [2:0] FWD_WB_PC4 = 3'b101;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  function automatic logic is_ex_fwd(input logic [2:0] sel);
    return (sel == FWD_EX_ALU) || (sel == FWD_EX_PC4);
  endfunction

  function automatic logic is_wb_fwd(input logic [2:0] sel);
    return (sel == FWD_WB_ALU) || (sel == FWD_WB_MEM) || (sel == FWD_WB_PC4);
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// One ALU operand select: base value or one of five later-stage producers.
// Codes 110/111 fall back to the base value and raise the illegal flag.
module fwd_operand_mux
  import rv32i_pkg::*;
(
  input  logic [2:0]      sel,
  input  logic [XLEN-1:0] base_val,
  input  logic [XLEN-1:0] ex_alu,
  input  logic [XLEN-1:0] ex_pc4,
  input  logic [XLEN-1:0] wb_alu,
  input  logic [XLEN-1:0] wb_mem,
  input  logic [XLEN-1:0] wb_pc4,
  output logic [XLEN-1:0] operand,
  output logic            illegal
);

  always_comb begin
    operand = base_val;
    illegal = 1'b0;
    case (sel)
      FWD_NONE:   operand = base_val;
      FWD_EX_ALU: operand = ex_alu;
      FWD_EX_PC4: operand = ex_pc4;
      FWD_WB_ALU: operand = wb_alu;
      FWD_WB_MEM: operand = wb_mem;
      FWD_WB_PC4: operand = wb_pc4;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_operand_fwd_stage.sv
// EX-stage operand forwarding and EX/MEM pipeline register with stall/flush.
// Define FWD_STATS_EN to add saturating forward-usage counters.
module ex_operand_fwd_stage
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [2:0]      fwd_sel_0,
  input  logic [2:0]      fwd_sel_1,
  input  logic [XLEN-1:0] rs1_data_ID_EXE,
  input  logic [XLEN-1:0] rs2_data_ID_EXE,
  input  logic [XLEN-1:0] alu_result_EX_MEM_in,
  input  logic [XLEN-1:0] pc_plus4_ID_EXE,
  input  logic [4:0]      rd_ID_EXE,
  input  logic            reg_write_ID_EXE,
  input  logic            mem_write_ID_EXE,
  input  logic            mem_read_ID_EXE,
  input  logic [1:0]      memtoreg_ID_EXE,
  input  logic            valid_ID_EXE,
  input  logic [XLEN-1:0] mem_data_MEM_WB,
  input  logic [XLEN-1:0] alu_result_MEM_WB,
  input  logic [XLEN-1:0] pc_plus4_MEM_WB,
  output logic [XLEN-1:0] operand_0,
  output logic [XLEN-1:0] operand_1,
  output logic [XLEN-1:0] alu_result_EX_MEM,
  output logic [XLEN-1:0] store_data_EX_MEM,
  output logic [XLEN-1:0] pc_plus4_EX_MEM,
  output logic [4:0]      rd_EX_MEM,
  output logic            reg_write_EX_MEM,
  output logic            mem_write_EX_MEM,
  output logic            mem_read_EX_MEM,
  output logic            valid_EX_MEM,
  output logic [1:0]      memtoreg_EX_MEM,
`ifdef FWD_STATS_EN
  output logic [31:0]     fwd_ex_count,
  output logic [31:0]     fwd_wb_count,
`endif
  output logic            illegal_fwd
);

  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_read_q, mem_read_d;
  logic            valid_q, valid_d;
  logic [1:0]      memtoreg_q, memtoreg_d;
  logic            illegal_0, illegal_1;

  // Codes 001/010 loop back from this block's own registered outputs.
  fwd_operand_mux u_mux_0 (
    .sel      (fwd_sel_0),
    .base_val (rs1_data_ID_EXE),
    .ex_alu   (alu_result_q),
    .ex_pc4   (pc_plus4_q),
    .wb_alu   (alu_result_MEM_WB),
    .wb_mem   (mem_data_MEM_WB),
    .wb_pc4   (pc_plus4_MEM_WB),
    .operand  (operand_0),
    .illegal  (illegal_0)
  );

  fwd_operand_mux u_mux_1 (
    .sel      (fwd_sel_1),
    .base_val (rs2_data_ID_EXE),
    .ex_alu   (alu_result_q),
    .ex_pc4   (pc_plus4_q),
    .wb_alu   (alu_result_MEM_WB),
    .wb_mem   (mem_data_MEM_WB),
    .wb_pc4   (pc_plus4_MEM_WB),
    .operand  (operand_1),
    .illegal  (illegal_1)
  );

  assign illegal_fwd = illegal_0 | illegal_1;

  // Flush only kills the control bits; data fields are don't-care in a bubble.
  always_comb begin
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    valid_d      = valid_q;
    memtoreg_d   = memtoreg_q;
    if (flush) begin
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      valid_d     = 1'b0;
    end else if (!stall) begin
      alu_result_d = alu_result_EX_MEM_in;
      store_data_d = operand_1;
      pc_plus4_d   = pc_plus4_ID_EXE;
      rd_d         = rd_ID_EXE;
      reg_write_d  = reg_write_ID_EXE & valid_ID_EXE;
      mem_write_d  = mem_write_ID_EXE & valid_ID_EXE;
      mem_read_d   = mem_read_ID_EXE & valid_ID_EXE;
      valid_d      = valid_ID_EXE;
      memtoreg_d   = memtoreg_ID_EXE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      valid_q      <= 1'b0;
      memtoreg_q   <= M2R_ALU;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      valid_q      <= valid_d;
      memtoreg_q   <= memtoreg_d;
    end
  end

  assign alu_result_EX_MEM = alu_result_q;
  assign store_data_EX_MEM = store_data_q;
  assign pc_plus4_EX_MEM   = pc_plus4_q;
  assign rd_EX_MEM         = rd_q;
  assign reg_write_EX_MEM  = reg_write_q;
  assign mem_write_EX_MEM  = mem_write_q;
  assign mem_read_EX_MEM   = mem_read_q;
  assign valid_EX_MEM      = valid_q;
  assign memtoreg_EX_MEM   = memtoreg_q;

`ifdef FWD_STATS_EN
  logic        stat_load;
  logic [1:0]  ex_inc, wb_inc;
  logic [32:0] ex_sum, wb_sum;
  logic [31:0] fwd_ex_count_q, fwd_ex_count_d;
  logic [31:0] fwd_wb_count_q, fwd_wb_count_d;

  assign stat_load = !stall && !flush && valid_ID_EXE;
  assign ex_inc = {1'b0, is_ex_fwd(fwd_sel_0)} + {1'b0, is_ex_fwd(fwd_sel_1)};
  assign wb_inc = {1'b0, is_wb_fwd(fwd_sel_0)} + {1'b0, is_wb_fwd(fwd_sel_1)};

  // Carry out of the 33-bit sum means the counter would wrap: pin to all-ones.
  always_comb begin
    ex_sum         = {1'b0, fwd_ex_count_q} + {31'b0, ex_inc};
    wb_sum         = {1'b0, fwd_wb_count_q} + {31'b0, wb_inc};
    fwd_ex_count_d = fwd_ex_count_q;
    fwd_wb_count_d = fwd_wb_count_q;
    if (stat_load) begin
      fwd_ex_count_d = ex_sum[32] ? 32'hFFFF_FFFF : ex_sum[31:0];
      fwd_wb_count_d = wb_sum[32] ? 32'hFFFF_FFFF : wb_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_ex_count_q <= '0;
      fwd_wb_count_q <= '0;
    end else begin
      fwd_ex_count_q <= fwd_ex_count_d;
      fwd_wb_count_q <= fwd_wb_count_d;
    end
  end

  assign fwd_ex_count = fwd_ex_count_q;
  assign fwd_wb_count = fwd_wb_count_q;
`endif

endmodule
